// File: rtl/addr_4_bit.sv
// Registered WIDTH-bit ripple-carry adder with carry, signed-overflow and zero flags.
// Latency is one clk. There is no handshake: every edge captures a new result.

module addr_4_bit_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);
  logic p;

  assign p       = a_i ^ b_i;
  assign sum_o   = p ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & p);
endmodule

module addr_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_d;
  logic             cout_d, ovf_d, zero_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, zero_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    addr_4_bit_fa u_fa (
      .a_i     (A[i]),
      .b_i     (B[i]),
      .c_i     (carry[i]),
      .sum_o   (s_d[i]),
      .carry_o (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];
  assign ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
  assign zero_d = (s_d == '0);

  // Reset clears every flag, including zero, even though s is also cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_addr_4_bit.sv
// Directed and random bench for addr_4_bit with an expected-result queue.
// Inputs are driven 1 time unit after a rising edge and checked 1 unit after the next one.

module tb_addr_4_bit;
  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic       cin;
  logic [3:0] s;
  logic       cout, ovf, zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  addr_4_bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .s    (s),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );

  function automatic exp_t model(input logic r, input logic [3:0] a,
                                 input logic [3:0] b, input logic c);
    exp_t       e;
    logic [4:0] full;
    full = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (r) begin
      e = '0;
    end else begin
      e.s    = full[3:0];
      e.cout = full[4];
      e.ovf  = (a[3] == b[3]) && (full[3] != a[3]);
      e.zero = (full[3:0] == 4'd0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".s"},    s,            e.s);
    check({tag, ".cout"}, {3'b0, cout}, {3'b0, e.cout});
    check({tag, ".ovf"},  {3'b0, ovf},  {3'b0, e.ovf});
    check({tag, ".zero"}, {3'b0, zero}, {3'b0, e.zero});
  endtask

  // Drive now (just after an edge), then compare one edge later
  task automatic step(input string tag, input logic r, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
    rst = r; A = a; B = b; cin = c;
    sb_q.push_back(model(r, a, b, c));
    @(posedge clk);
    #1;
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      last_exp = sb_q.pop_front();
      check_outputs(tag, last_exp);
    end
  endtask

  initial begin
    rst = 1'b1; A = 4'd8; B = 4'd12; cin = 1'b0;
    @(posedge clk);
    #1;

    step("rst0", 1'b1, 4'd8, 4'd12, 1'b0);
    step("rst1", 1'b1, 4'd8, 4'd12, 1'b0);
    step("first", 1'b0, 4'b1000, 4'b1100, 1'b0);

    for (int i = 0; i < 11; i++) begin
      logic [3:0] a;
      a = 4'(8 + i);
      step($sformatf("inc%0d", i), 1'b0, a, 4'd12, 1'b0);
    end

    step("ff_cin",  1'b0, 4'd15, 4'd15, 1'b1);
    step("zeros",   1'b0, 4'd0,  4'd0,  1'b0);
    step("pos_ovf", 1'b0, 4'd7,  4'd1,  1'b0);
    step("wrap0",   1'b0, 4'd15, 4'd1,  1'b0);

    // Reset and input glitches between edges must not disturb the outputs
    rst = 1'b1; A = 4'd3; B = 4'd5; cin = 1'b1;
    #2;
    check_outputs("hold", last_exp);

    step("stream0", 1'b0, 4'd8, 4'd12, 1'b0);
    step("midrst",  1'b1, 4'd8, 4'd12, 1'b0);
    step("after",   1'b0, 4'd8, 4'd12, 1'b0);
    step("neg_ovf", 1'b0, 4'd8, 4'd8,  1'b0);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("rnd%0d", i), 1'b0, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_4_bit.md
ADDR_4_BIT -- requirements
Module: addr_4_bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/sum width; all requirements below use WIDTH=4 values.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
REQ-004 Port: A  input  WIDTH  unsigned/two's-complement operand A.
REQ-005 Port: B  input  WIDTH  unsigned/two's-complement operand B.
REQ-006 Port: cin  input  1  carry-in.
REQ-007 Port: s  output  WIDTH  registered sum bits.
REQ-008 Port: cout  output  1  registered carry-out of the MSB.
REQ-009 Port: ovf  output  1  registered signed overflow flag.
REQ-010 Port: zero  output  1  registered flag, high when registered s is all zeros.

Function
REQ-011 The combinational core SHALL compute {cout_n, s_n} = A + B + cin, full WIDTH+1-bit result, no truncation of the carry.
REQ-012 The core SHALL be a ripple chain of WIDTH identical full-adder cells: bit 0 takes cin, bit i takes the carry of bit i-1, and the carry of bit WIDTH-1 is cout_n.
REQ-013 Each full-adder cell SHALL produce sum = a XOR b XOR c and carry = (a AND b) OR (c AND (a XOR b)).
REQ-014 ovf_n SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-015 zero_n SHALL be high when s_n equals 0, regardless of cout_n.
REQ-016 On each rising clk edge with rst low, s, cout, ovf and zero SHALL load s_n, cout_n, ovf_n and zero_n.
REQ-017 Latency SHALL be exactly one clock: inputs stable before edge k appear on the outputs after edge k.
REQ-018 Inputs MAY change every cycle; every edge SHALL capture an independent result, with no handshake and no stall.
REQ-019 Wrap-around: a sum of 2^WIDTH or more SHALL leave s = (A+B+cin) mod 2^WIDTH and cout = 1.
REQ-020 Outputs SHALL NOT change between clock edges, including on input glitches.
REQ-021 The block SHALL contain no other state than the four output registers.

Reset
REQ-022 When rst is high at a rising clk edge, s SHALL be set to 0, cout to 0, ovf to 0 and zero to 0, overriding the arithmetic result.
REQ-023 Reset asserted mid-stream SHALL discard the result of the inputs presented at that edge.
REQ-024 On the first edge with rst low, the outputs SHALL load the result of the inputs presented at that edge.
REQ-025 Reset SHALL have no asynchronous effect; assertion between edges SHALL NOT change the outputs.
REQ-026 Before the first reset edge, output values are undefined; benches SHALL apply rst for at least one edge first.

Verification
REQ-027 Hold rst=1 for 2 edges with A=8, B=12, cin=0 -> s=0, cout=0, ovf=0, zero=0.
REQ-028 rst=0, A=4'b1000, B=4'b1100, cin=0 -> one edge later s=4'b0100, cout=1, ovf=1, zero=0.
REQ-029 Starting from A=8, B=12, cin=0, increment A by 1 per cycle for 10 cycles, wrapping 15->0 -> each output equals the previous cycle's (A+12) mod 16, with cout=1 for A=8..15 and cout=0 for A=0..2.
REQ-030 A=15, B=15, cin=1 -> s=15, cout=1, ovf=0; then A=0, B=0, cin=0 -> s=0, cout=0, zero=1.
REQ-031 A=7, B=1, cin=0 -> s=8, cout=0, ovf=1; A=15, B=1, cin=0 -> s=0, cout=1, zero=1, ovf=0.
REQ-032 With A=8, B=12 streaming, assert rst for one edge mid-stream -> outputs all 0 after that edge, and the correct sum after the next edge with rst low.
